fetch_unit: RTL and testbench

Instruction-fetch stage for the 5-stage PA-RISC pipeline, sitting directly upstream of the decode stage. It owns the front/back program-counter pair that implements the architectural one-instruction branch delay slot. It drives the combinational instruction memory and loads the IF/ID pipeline latch. It also absorbs hazard stalls and applies taken-branch redirects, deferring a redirect that arrives during a stall.

---
 rtl/fetch_unit.sv | 120 ++++++++++++
 tb/tb_fetch_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage for the 5-stage PA-RISC pipeline.
// Keeps the front/back PC pair that implements the one-instruction branch
// delay slot. It drives the combinational instruction memory and loads the
// IF/ID latch. Hazard stalls are absorbed here. A redirect that arrives
// during a stall is deferred until the stall drops.
// Optional feature macro: FETCH_NULLIFY_EN adds the branch_nullify port.
// With that port, a redirect can squash its delay-slot instruction.
module fetch_unit #(
    parameter int                ADDR_W      = 8,
    parameter int                INSTR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_FRONT = ADDR_W'(0),
    parameter logic [ADDR_W-1:0] RESET_BACK  = ADDR_W'(4)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
`ifdef FETCH_NULLIFY_EN
    input  logic               branch_nullify,
`endif
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [ADDR_W-1:0]  ifid_pc,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic               ifid_valid,
    output logic               redirect_pending,
    output logic [15:0]        fetch_count
);

    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_PENDING = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] front_pc;
    logic [ADDR_W-1:0] back_pc;
    logic [ADDR_W-1:0] pend_target;

    logic              redirect_now;
    logic [ADDR_W-1:0] redirect_target;
    logic              capture_valid;

`ifdef FETCH_NULLIFY_EN
    logic pend_nullify;
    logic slot_nullify;
    logic apply_nullify;

    // A deferred redirect uses the nullify bit that was latched with it.
    // A live redirect uses the port directly.
    assign apply_nullify = (state == ST_PENDING) ? pend_nullify : branch_nullify;
    // The delay slot that follows a nullifying redirect is captured as a bubble.
    assign capture_valid = !slot_nullify;
`else
    assign capture_valid = 1'b1;
`endif

    // A redirect is applied on any unstalled edge.
    // It comes either from a live branch in RUN or from the latched one in PENDING.
    // While PENDING, the live branch inputs are ignored.
    always_comb begin
        redirect_now    = 1'b0;
        redirect_target = branch_target;
        if (!stall) begin
            if (state == ST_PENDING) begin
                redirect_now    = 1'b1;
                redirect_target = pend_target;
            end else if (branch_taken) begin
                redirect_now    = 1'b1;
            end
        end
    end

    assign imem_addr        = front_pc;
    assign redirect_pending = (state == ST_PENDING);

    // Main pipeline step: on an unstalled edge, capture IF/ID and advance the PC pair.
    // On a stalled edge, hold everything and, if needed, latch a redirect for later.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_RUN;
            front_pc    <= RESET_FRONT;
            back_pc     <= RESET_BACK;
            pend_target <= '0;
            ifid_pc     <= '0;
            ifid_instr  <= '0;
            ifid_valid  <= 1'b0;
            fetch_count <= 16'd0;
        end else if (!stall) begin
            ifid_pc    <= front_pc;
            ifid_instr <= capture_valid ? imem_data : '0;
            ifid_valid <= capture_valid;
            if (capture_valid) begin
                fetch_count <= fetch_count + 16'd1;
            end
            front_pc <= back_pc;
            back_pc  <= redirect_now ? redirect_target : back_pc + ADDR_W'(4);
            state    <= ST_RUN;
        end else if ((state == ST_RUN) && branch_taken) begin
            pend_target <= branch_target;
            state       <= ST_PENDING;
        end
    end

`ifdef FETCH_NULLIFY_EN
    // Nullify bookkeeping. The latched bit travels with a deferred redirect.
    // The slot flag squashes exactly one unstalled capture after the redirect edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_nullify <= 1'b0;
            slot_nullify <= 1'b0;
        end else if (!stall) begin
            slot_nullify <= redirect_now && apply_nullify;
            pend_nullify <= 1'b0;
        end else if ((state == ST_RUN) && branch_taken) begin
            pend_nullify <= branch_nullify;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven directed test for fetch_unit.
// The instruction memory returns 32'hA0 + address.
// Build with FETCH_NULLIFY_EN defined to also exercise delay-slot nullification.
module tb_fetch_unit;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 32;

    typedef struct {
        bit               rst;
        bit               stall;
        bit               br;
        bit               nul;
        logic [ADDR_W-1:0] tgt;
        logic [ADDR_W-1:0] exp_pc;
        logic              exp_valid;
        logic [INSTR_W-1:0] exp_instr;
        logic [ADDR_W-1:0] exp_addr;
        logic              exp_pend;
        logic [15:0]       exp_cnt;
    } vec_t;

    logic               clk = 1'b0;
    logic               reset;
    logic               stall;
    logic               branch_taken;
    logic [ADDR_W-1:0]  branch_target;
`ifdef FETCH_NULLIFY_EN
    logic               branch_nullify;
`endif
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic [ADDR_W-1:0]  ifid_pc;
    logic [INSTR_W-1:0] ifid_instr;
    logic               ifid_valid;
    logic               redirect_pending;
    logic [15:0]        fetch_count;

    int compared   = 0;
    int mismatched = 0;
    bit saw_spurious = 1'b0;
    vec_t vecs[$];

    fetch_unit dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
`ifdef FETCH_NULLIFY_EN
        .branch_nullify   (branch_nullify),
`endif
        .imem_addr        (imem_addr),
        .imem_data        (imem_data),
        .ifid_pc          (ifid_pc),
        .ifid_instr       (ifid_instr),
        .ifid_valid       (ifid_valid),
        .redirect_pending (redirect_pending),
        .fetch_count      (fetch_count)
    );

    // Free-running clock with a 10-unit period.
    always #5 clk = ~clk;

    // Combinational instruction memory model.
    assign imem_data = 32'hA0 + {24'h0, imem_addr};

    function automatic vec_t mk(bit rst, bit stl, bit br, bit nul, logic [7:0] tgt,
                                logic [7:0] pc, logic vld, logic [7:0] addr,
                                logic pend, logic [15:0] cnt);
        vec_t v;
        v.rst       = rst;
        v.stall     = stl;
        v.br        = br;
        v.nul       = nul;
        v.tgt       = tgt;
        v.exp_pc    = pc;
        v.exp_valid = vld;
        v.exp_instr = vld ? (32'hA0 + {24'h0, pc}) : 32'h0;
        v.exp_addr  = addr;
        v.exp_pend  = pend;
        v.exp_cnt   = cnt;
        return v;
    endfunction

    task automatic checkOutput(input string name, input int row,
                               input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL row %0d %s: got %0h expected %0h", row, name, got, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int row);
        @(negedge clk);
        reset         = v.rst;
        stall         = v.stall;
        branch_taken  = v.br;
        branch_target = v.tgt;
`ifdef FETCH_NULLIFY_EN
        branch_nullify = v.nul;
`endif
        @(posedge clk);
        #1;
        if (imem_addr == 8'h20) saw_spurious = 1'b1;
        checkOutput("ifid_pc",          row, 32'(ifid_pc),          32'(v.exp_pc));
        checkOutput("ifid_instr",       row, ifid_instr,            v.exp_instr);
        checkOutput("ifid_valid",       row, 32'(ifid_valid),       32'(v.exp_valid));
        checkOutput("imem_addr",        row, 32'(imem_addr),        32'(v.exp_addr));
        checkOutput("redirect_pending", row, 32'(redirect_pending), 32'(v.exp_pend));
        checkOutput("fetch_count",      row, 32'(fetch_count),      32'(v.exp_cnt));
    endtask

    initial begin
        reset         = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
`ifdef FETCH_NULLIFY_EN
        branch_nullify = 1'b0;
`endif

        //                rst stl br nul tgt    pc     vld addr   pnd cnt
        // reset, then four straight-line fetches
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 16'd0));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h00, 1, 8'h04, 0, 16'd1));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h04, 1, 8'h08, 0, 16'd2));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h08, 1, 8'h0C, 0, 16'd3));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h0C, 1, 8'h10, 0, 16'd4));
        // re-reset, then branch to 0x40 while front=8
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 16'd0));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h00, 1, 8'h04, 0, 16'd1));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h04, 1, 8'h08, 0, 16'd2));
        vecs.push_back(mk(0, 0, 1, 0, 8'h40, 8'h08, 1, 8'h0C, 0, 16'd3));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h0C, 1, 8'h40, 0, 16'd4));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h40, 1, 8'h44, 0, 16'd5));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h44, 1, 8'h48, 0, 16'd6));
        // three-cycle stall, then resume sequentially
        vecs.push_back(mk(0, 1, 0, 0, 8'h00, 8'h44, 1, 8'h48, 0, 16'd6));
        vecs.push_back(mk(0, 1, 0, 0, 8'h00, 8'h44, 1, 8'h48, 0, 16'd6));
        vecs.push_back(mk(0, 1, 0, 0, 8'h00, 8'h44, 1, 8'h48, 0, 16'd6));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h48, 1, 8'h4C, 0, 16'd7));
        // deferred redirect to 0x80; spurious 0x20 while pending and on release
        vecs.push_back(mk(0, 1, 1, 0, 8'h80, 8'h48, 1, 8'h4C, 1, 16'd7));
        vecs.push_back(mk(0, 1, 1, 0, 8'h20, 8'h48, 1, 8'h4C, 1, 16'd7));
        vecs.push_back(mk(0, 1, 0, 0, 8'h00, 8'h48, 1, 8'h4C, 1, 16'd7));
        vecs.push_back(mk(0, 0, 1, 0, 8'h20, 8'h4C, 1, 8'h50, 0, 16'd8));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h50, 1, 8'h80, 0, 16'd9));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h80, 1, 8'h84, 0, 16'd10));
        // redirect to 0xF8 and run across the address wrap
        vecs.push_back(mk(0, 0, 1, 0, 8'hF8, 8'h84, 1, 8'h88, 0, 16'd11));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h88, 1, 8'hF8, 0, 16'd12));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'hF8, 1, 8'hFC, 0, 16'd13));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'hFC, 1, 8'h00, 0, 16'd14));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h00, 1, 8'h04, 0, 16'd15));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h04, 1, 8'h08, 0, 16'd16));
        // enter PENDING, then reset while still stalled
        vecs.push_back(mk(0, 1, 1, 0, 8'h30, 8'h04, 1, 8'h08, 1, 16'd16));
        vecs.push_back(mk(1, 1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 16'd0));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h00, 1, 8'h04, 0, 16'd1));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h04, 1, 8'h08, 0, 16'd2));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i], i);
        end

        compared++;
        if (saw_spurious) begin
            mismatched++;
            $display("[TB] FAIL spurious_target: imem_addr reached 20 expected never");
        end

`ifdef FETCH_NULLIFY_EN
        // Hand-written nullify sequences, continuing from front=8.
        // Live nullifying branch to 0x40: pc 8 is kept, pc 12 becomes a bubble.
        applyStimulus(mk(0, 0, 1, 1, 8'h40, 8'h08, 1, 8'h0C, 0, 16'd3), 100);
        applyStimulus(mk(0, 0, 0, 0, 8'h00, 8'h0C, 0, 8'h40, 0, 16'd3), 101);
        applyStimulus(mk(0, 0, 0, 0, 8'h00, 8'h40, 1, 8'h44, 0, 16'd4), 102);
        // Deferred nullifying branch to 0x60: the nullify bit is latched with the target.
        applyStimulus(mk(0, 1, 1, 1, 8'h60, 8'h40, 1, 8'h44, 1, 16'd4), 103);
        applyStimulus(mk(0, 0, 0, 0, 8'h00, 8'h44, 1, 8'h48, 0, 16'd5), 104);
        applyStimulus(mk(0, 0, 0, 0, 8'h00, 8'h48, 0, 8'h60, 0, 16'd5), 105);
        applyStimulus(mk(0, 0, 0, 0, 8'h00, 8'h60, 1, 8'h64, 0, 16'd6), 106);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
